arb_grant_lock: RTL and testbench

Burst-lock and data-steering stage directly downstream of the fixed-priority combinational arbiter. The block presents requester valids to the arbiter and captures the arbiter's winner while idle. It then holds that grant for a full multi-beat burst and muxes the owner's data onto a single valid/ready output channel. It releases on the owner's last beat, or forcibly after MaxBurst beats.

---
 rtl/arb_grant_lock.sv | 133 +++++++++++++
 tb/tb_arb_grant_lock.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_lock.sv
// arb_grant_lock: burst-lock and data-steering stage that sits behind a fixed-priority
// combinational arbiter. While idle it forwards requester valids to the arbiter and captures
// the winner. It then holds that grant for a whole burst, steering the owner's beats onto one
// valid/ready channel. The lock is released on the owner's last beat, or forcibly after
// MaxBurst beats.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     per-requester beat valid
//   req_data      per-requester payload, requester i at [i*DataWidth +: DataWidth]
//   req_last      per-requester last-beat flag
//   req_ready     per-requester accept (only the owner's bit can be set)
//   arb_request   request vector to the arbiter (zero while locked)
//   arb_grant     one-hot grant from the arbiter
//   arb_select    winner index from the arbiter
//   out_valid     output beat valid
//   out_data      output payload
//   out_last      output last flag (also set on a forced final beat)
//   out_ready     downstream accept
//   owner         index of the locked requester (holds its value in idle)
//   locked        burst in progress
//   beat_count    beats accepted in the current burst
//   err_overlong  sticky flag: a burst was cut at MaxBurst
//   err_clear     synchronous clear of err_overlong
module arb_grant_lock #(
  parameter int unsigned NumRequests = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MaxBurst    = 16,
  localparam int unsigned SelWidth   = (NumRequests > 1) ? $clog2(NumRequests) : 1,
  localparam int unsigned CntWidth   = $clog2(MaxBurst + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumRequests-1:0]         req_valid,
  input  logic [NumRequests*DataWidth-1:0] req_data,
  input  logic [NumRequests-1:0]         req_last,
  output logic [NumRequests-1:0]         req_ready,
  output logic [NumRequests-1:0]         arb_request,
  input  logic [NumRequests-1:0]         arb_grant,
  input  logic [SelWidth-1:0]            arb_select,
  output logic                           out_valid,
  output logic [DataWidth-1:0]           out_data,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [SelWidth-1:0]            owner,
  output logic                           locked,
  output logic [CntWidth-1:0]            beat_count,
  output logic                           err_overlong,
  input  logic                           err_clear
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               state_q;
  logic [SelWidth-1:0]  owner_q;
  logic [CntWidth-1:0]  beat_q;
  logic                 err_q;

  logic                 is_locked;
  logic                 own_valid;
  logic                 own_last;
  logic [DataWidth-1:0] own_data;
  logic                 forced_last;
  logic                 transfer;
  logic                 overlong_evt;
  logic                 grant_ok;

  assign is_locked = (state_q == StLocked);
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = req_data[32'(owner_q) * DataWidth +: DataWidth];

  assign forced_last  = is_locked && (beat_q == CntWidth'(MaxBurst - 1));
  assign transfer     = is_locked && own_valid && out_ready;
  assign overlong_evt = transfer && forced_last && !own_last;

  // arb_select is only trusted when some grant bit is set; it may float otherwise.
  assign grant_ok = (|arb_grant) && (32'(arb_select) < NumRequests);

  always_comb begin
    // Gate with rst so the request vector is zero during reset even though state is idle.
    arb_request = (!is_locked && !rst) ? req_valid : '0;
    out_valid   = is_locked && own_valid;
    out_data    = is_locked ? own_data : '0;
    out_last    = is_locked && (own_last || forced_last);
    req_ready   = '0;
    if (is_locked) begin
      req_ready[owner_q] = out_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // Set after clear so a simultaneous overlong event wins.
      if (err_clear) begin
        err_q <= 1'b0;
      end
      if (overlong_evt) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (grant_ok) begin
            owner_q <= arb_select;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (transfer) begin
            if (own_last || forced_last) begin
              state_q <= StIdle;
              beat_q  <= '0;
            end else begin
              beat_q  <= beat_q + CntWidth'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign owner        = owner_q;
  assign locked       = is_locked;
  assign beat_count   = beat_q;
  assign err_overlong = err_q;

endmodule

// File: tb/tb_arb_grant_lock.sv
module tb_arb_grant_lock;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     arb_request;
  logic [NR-1:0]     arb_grant;
  logic [1:0]        arb_select;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [1:0]        owner;
  logic              locked;
  logic [2:0]        beat_count;
  logic              err_overlong;
  logic              err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  arb_grant_lock #(
    .NumRequests(NR),
    .DataWidth  (DW),
    .MaxBurst   (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .arb_request (arb_request),
    .arb_grant   (arb_grant),
    .arb_select  (arb_select),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .owner       (owner),
    .locked      (locked),
    .beat_count  (beat_count),
    .err_overlong(err_overlong),
    .err_clear   (err_clear)
  );

  // Fixed-priority arbiter: lowest index wins.
  always_comb begin
    arb_grant  = '0;
    arb_select = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (arb_request[i]) begin
        arb_grant  = '0;
        arb_grant[i] = 1'b1;
        arb_select = 2'(i);
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    req_data[idx*DW +: DW] = d;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0101;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    #1;
    // Reset with no clock edge yet
    check_eq("rst_locked", locked, 0);
    check_eq("rst_arb_request", arb_request, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_err", err_overlong, 0);
    check_eq("rst_beat", beat_count, 0);
    req_valid = '0;
    #1 rst = 1'b0;
    repeat (5) tick();
    check_eq("idle_locked", locked, 0);

    // Single burst on requester 2
    req_valid = 4'b0100;
    set_data(2, 32'hA0);
    out_ready = 1'b1;
    #1;
    check_eq("sb_arb_request", arb_request, 4'b0100);
    check_eq("sb_idle_out_valid", out_valid, 0);
    check_eq("sb_idle_req_ready", req_ready, 0);
    tick();
    check_eq("sb_locked", locked, 1);
    check_eq("sb_owner", owner, 2);
    check_eq("sb_out_valid", out_valid, 1);
    check_eq("sb_data0", out_data, 32'hA0);
    check_eq("sb_last0", out_last, 0);
    check_eq("sb_beat0", beat_count, 0);
    check_eq("sb_req_ready", req_ready, 4'b0100);
    check_eq("sb_arb_req_locked", arb_request, 0);
    tick();
    set_data(2, 32'hA1);
    #1;
    check_eq("sb_data1", out_data, 32'hA1);
    check_eq("sb_beat1", beat_count, 1);
    check_eq("sb_last1", out_last, 0);
    tick();
    set_data(2, 32'hA2);
    req_last = 4'b0100;
    #1;
    check_eq("sb_data2", out_data, 32'hA2);
    check_eq("sb_beat2", beat_count, 2);
    check_eq("sb_last2", out_last, 1);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check_eq("sb_rel_locked", locked, 0);
    check_eq("sb_rel_beat", beat_count, 0);
    check_eq("sb_rel_out_valid", out_valid, 0);
    check_eq("sb_rel_out_data", out_data, 0);
    check_eq("sb_rel_out_last", out_last, 0);

    // Priority plus lock
    tick();
    req_valid = 4'b1010;
    set_data(1, 32'hB0);
    #1;
    check_eq("pl_arb_request", arb_request, 4'b1010);
    tick();
    req_valid = 4'b1011;
    #1;
    check_eq("pl_owner", owner, 1);
    check_eq("pl_req_ready", req_ready, 4'b0010);
    check_eq("pl_arb_req_locked", arb_request, 0);
    tick();
    req_last = 4'b0010;
    #1;
    check_eq("pl_owner_hold", owner, 1);
    check_eq("pl_req_ready_hold", req_ready, 4'b0010);
    check_eq("pl_last", out_last, 1);
    tick();
    req_valid = 4'b1001;
    req_last  = '0;
    #1;
    check_eq("pl_gap_locked", locked, 0);
    check_eq("pl_gap_arb_request", arb_request, 4'b1001);
    tick();
    check_eq("pl_new_locked", locked, 1);
    check_eq("pl_new_owner", owner, 0);
    req_last = 4'b0001;
    tick();
    req_valid = '0;
    req_last  = '0;

    // Backpressure on requester 3
    tick();
    req_valid = 4'b1000;
    tick();
    out_ready = 1'b1;
    #1;
    check_eq("bp_owner", owner, 3);
    check_eq("bp_ready_a", req_ready, 4'b1000);
    check_eq("bp_beat_a", beat_count, 0);
    tick();
    out_ready = 1'b0;
    #1;
    check_eq("bp_ready_b", req_ready, 0);
    check_eq("bp_beat_b", beat_count, 1);
    check_eq("bp_valid_b", out_valid, 1);
    tick();
    check_eq("bp_ready_c", req_ready, 0);
    check_eq("bp_beat_c", beat_count, 1);
    out_ready = 1'b1;
    req_last  = 4'b1000;
    #1;
    check_eq("bp_ready_d", req_ready, 4'b1000);
    check_eq("bp_last_d", out_last, 1);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check_eq("bp_rel_locked", locked, 0);

    // Overlong burst, then cleared
    tick();
    req_valid = 4'b0010;
    tick();
    check_eq("ol_locked", locked, 1);
    tick();
    tick();
    tick();
    check_eq("ol_beat3", beat_count, 3);
    check_eq("ol_forced_last", out_last, 1);
    check_eq("ol_err_pre", err_overlong, 0);
    tick();
    req_valid = '0;
    #1;
    check_eq("ol_rel_locked", locked, 0);
    check_eq("ol_err_set", err_overlong, 1);
    check_eq("ol_rel_beat", beat_count, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1;
    check_eq("ol_err_cleared", err_overlong, 0);

    // Overlong with clear in the forcing cycle: set wins
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    err_clear = 1'b1;
    #1;
    check_eq("ol2_forced_last", out_last, 1);
    tick();
    err_clear = 1'b0;
    req_valid = '0;
    #1;
    check_eq("ol2_err_set_wins", err_overlong, 1);
    check_eq("ol2_locked", locked, 0);

    // Reset mid-burst
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    tick();
    check_eq("rm_beat2", beat_count, 2);
    rst = 1'b1;
    #1;
    check_eq("rm_locked", locked, 0);
    check_eq("rm_req_ready", req_ready, 0);
    check_eq("rm_out_valid", out_valid, 0);
    check_eq("rm_out_last", out_last, 0);
    check_eq("rm_arb_request", arb_request, 0);
    check_eq("rm_beat", beat_count, 0);
    check_eq("rm_err", err_overlong, 0);
    rst = 1'b0;
    tick();
    check_eq("rm_new_locked", locked, 1);
    check_eq("rm_new_owner", owner, 2);
    check_eq("rm_new_beat", beat_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
